// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and the delay-line stage type for
// the 800x600@72 VGA framebuffer fetch path.
package vga_pkg;

  localparam int unsigned VgaHSize = 800;
  localparam int unsigned VgaHFp   = 856;
  localparam int unsigned VgaHSp   = 976;
  localparam int unsigned VgaHMax  = 1040;
  localparam int unsigned VgaVSize = 600;
  localparam int unsigned VgaVFp   = 637;
  localparam int unsigned VgaVSp   = 643;
  localparam int unsigned VgaVMax  = 666;

  localparam int unsigned FB_W  = 400;
  localparam int unsigned FB_H  = 300;
  localparam int unsigned FB_AW = 17;

  typedef logic [11:0] rgb444_t;

  // One stage-0 snapshot, carried alongside the BRAM read.
  typedef struct packed {
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        active;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        blk;
  } stage_t;

  function automatic logic in_window(input logic [11:0] c, input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_fb_fetch_if.sv
// Framebuffer-fetch bundle: BRAM read port, pause request and the aligned pixel
// stream towards the RGB444->RGB888 converter.
interface vga_fb_fetch_if;
  import vga_pkg::*;

  logic             pause_req;
  logic [FB_AW-1:0] fb_addr;
  rgb444_t          fb_rdata;
  rgb444_t          rgb444;
  logic [11:0]      hdata;
  logic [11:0]      vdata;
  logic             hsync;
  logic             vsync;
  logic             data_enable;
  logic             to_black;
  logic             frame_start;

  modport master (
    input  pause_req, fb_rdata,
    output fb_addr, rgb444, hdata, vdata, hsync, vsync, data_enable, to_black, frame_start
  );

  modport slave (
    output pause_req, fb_rdata,
    input  fb_addr, rgb444, hdata, vdata, hsync, vsync, data_enable, to_black, frame_start
  );

endinterface

// File: rtl/vga_delay_line.sv
// Shift register of stage-0 snapshots so timing flags line up with BRAM read data.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t pipe_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/vga_fb_fetch.sv
// VGA timing generator and 2x-scaled framebuffer fetcher; outputs are aligned with
// BRAM read data RD_LAT cycles after the stage-0 coordinate.
module vga_fb_fetch
  import vga_pkg::*;
#(
  parameter int unsigned HSIZE  = VgaHSize,
  parameter int unsigned HFP    = VgaHFp,
  parameter int unsigned HSP    = VgaHSp,
  parameter int unsigned HMAX   = VgaHMax,
  parameter int unsigned VSIZE  = VgaVSize,
  parameter int unsigned VFP    = VgaVFp,
  parameter int unsigned VSP    = VgaVSp,
  parameter int unsigned VMAX   = VgaVMax,
  parameter int unsigned HSPP   = 1,
  parameter int unsigned VSPP   = 1,
  parameter int unsigned FB_W   = vga_pkg::FB_W,
  parameter int unsigned FB_H   = vga_pkg::FB_H,
  parameter int unsigned RD_LAT = 2
) (
  input logic            clk,
  input logic            reset,
  vga_fb_fetch_if.master bus
);

  localparam logic [11:0] HSizeC = 12'(HSIZE);
  localparam logic [11:0] HFpC   = 12'(HFP);
  localparam logic [11:0] HSpC   = 12'(HSP);
  localparam logic [11:0] HLastC = 12'(HMAX - 1);
  localparam logic [11:0] VSizeC = 12'(VSIZE);
  localparam logic [11:0] VFpC   = 12'(VFP);
  localparam logic [11:0] VSpC   = 12'(VSP);
  localparam logic [11:0] VLastC = 12'(VMAX - 1);
  localparam logic [11:0] FbW12  = 12'(FB_W);
  localparam logic [11:0] FbH12  = 12'(FB_H);
  localparam logic [FB_AW-1:0] FbWC = FB_AW'(FB_W);
  localparam logic HsOn = (HSPP != 0);
  localparam logic VsOn = (VSPP != 0);

  logic [11:0]      hcnt_q, hcnt_d;
  logic [11:0]      vcnt_q, vcnt_d;
  logic [FB_AW-1:0] row_base_q, row_base_d;
  logic             blk_q, blk_d;
  logic             h_wrap, v_wrap, origin, active, in_fb;
  logic [FB_AW-1:0] fb_addr;
  stage_t           st0, st_out;

  always_comb begin
    h_wrap = (hcnt_q == HLastC);
    v_wrap = (vcnt_q == VLastC);
    origin = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    active = (hcnt_q < HSizeC) && (vcnt_q < VSizeC);
    // Guards the read address should the screen ever exceed twice the buffer size.
    in_fb  = ({1'b0, hcnt_q[11:1]} < FbW12) && ({1'b0, vcnt_q[11:1]} < FbH12);

    hcnt_d     = h_wrap ? 12'd0 : hcnt_q + 12'd1;
    vcnt_d     = vcnt_q;
    row_base_d = row_base_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? 12'd0 : vcnt_q + 12'd1;
      // Frame wrap clears before the odd-line advance can apply.
      if (v_wrap) begin
        row_base_d = '0;
      end else if (vcnt_q[0]) begin
        row_base_d = row_base_q + FbWC;
      end
    end

    blk_d   = origin ? bus.pause_req : blk_q;
    fb_addr = (active && in_fb) ?
              row_base_q + {{(FB_AW - 11){1'b0}}, hcnt_q[11:1]} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      row_base_q <= '0;
      blk_q      <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      row_base_q <= row_base_d;
      blk_q      <= blk_d;
    end
  end

  always_comb begin
    st0.hcnt   = hcnt_q;
    st0.vcnt   = vcnt_q;
    st0.active = active;
    st0.hs     = in_window(hcnt_q, HFpC, HSpC);
    st0.vs     = in_window(vcnt_q, VFpC, VSpC);
    st0.fs     = origin;
    st0.blk    = blk_d;
  end

  vga_delay_line #(
    .Depth (RD_LAT)
  ) u_delay (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (st0),
    .q_o   (st_out)
  );

  assign bus.fb_addr     = fb_addr;
  assign bus.rgb444      = st_out.active ? bus.fb_rdata : 12'h000;
  assign bus.hdata       = st_out.hcnt;
  assign bus.vdata       = st_out.vcnt;
  assign bus.hsync       = st_out.hs ? HsOn : ~HsOn;
  assign bus.vsync       = st_out.vs ? VsOn : ~VsOn;
  assign bus.data_enable = st_out.active;
  assign bus.to_black    = st_out.blk;
  assign bus.frame_start = st_out.fs;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Three fetchers: full 800x600 timing (latency 2) and shrunken timing (latency 1 and 4),
// each checked cycle by cycle against a scoreboard plus directed boundary checks.
module tb_vga_fb_fetch;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  logic [2:0] pause = 3'b000;
  int unsigned total = 0;
  int unsigned bad = 0;

  always #10 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        blk;
  } exp_t;

  function automatic logic [11:0] pat(input int unsigned a);
    logic [31:0] x;
    x = a * 37 + 291;
    return (a == 0) ? 12'hABC : (x[11:0] ^ x[19:8]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam bit Sm = (g != 0);
    localparam int unsigned Lat = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int unsigned HS = Sm ? 16 : 800;
    localparam int unsigned HF = Sm ? 18 : 856;
    localparam int unsigned HP = Sm ? 21 : 976;
    localparam int unsigned HM = Sm ? 24 : 1040;
    localparam int unsigned VS = Sm ? 8 : 600;
    localparam int unsigned VF = Sm ? 9 : 637;
    localparam int unsigned VP = Sm ? 11 : 643;
    localparam int unsigned VM = Sm ? 12 : 666;
    localparam int unsigned FW = Sm ? 8 : 400;
    localparam int unsigned FH = Sm ? 4 : 300;

    vga_fb_fetch_if u_if ();
    logic [11:0] rd_pipe [4];
    exp_t        q [$];
    int unsigned mh, mv;
    logic        mblk;

    assign u_if.pause_req = pause[g];
    assign u_if.fb_rdata  = rd_pipe[Lat-1];

    vga_fb_fetch #(
      .HSIZE  (HS),
      .HFP    (HF),
      .HSP    (HP),
      .HMAX   (HM),
      .VSIZE  (VS),
      .VFP    (VF),
      .VSP    (VP),
      .VMAX   (VM),
      .HSPP   (1),
      .VSPP   (1),
      .FB_W   (FW),
      .FB_H   (FH),
      .RD_LAT (Lat)
    ) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .bus   (u_if)
    );

    // BRAM model with Lat registered read stages.
    always @(posedge clk) begin
      rd_pipe[0] <= pat(32'(u_if.fb_addr));
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always @(negedge clk) begin
      exp_t e, o;
      bit act;
      int unsigned addr;
      if (rst[g]) begin
        mh = 0;
        mv = 0;
        mblk = 1'b0;
        q.delete();
        for (int i = 0; i < int'(Lat); i++) q.push_back('0);
      end else begin
        act  = (mh < HS) && (mv < VS);
        addr = act ? (mv / 2) * FW + mh / 2 : 0;
        check($sformatf("d%0d.fb_addr(%0d,%0d)", g, mh, mv), 32'(u_if.fb_addr), addr);
        e.rgb = act ? pat(addr) : 12'h000;
        e.h   = 12'(mh);
        e.v   = 12'(mv);
        e.hs  = (mh >= HF) && (mh < HP);
        e.vs  = (mv >= VF) && (mv < VP);
        e.de  = act;
        e.fs  = (mh == 0) && (mv == 0);
        if (e.fs) mblk = pause[g];
        e.blk = mblk;
        q.push_back(e);
        o = q.pop_front();
        check($sformatf("d%0d.rgb444", g), 32'(u_if.rgb444), 32'(o.rgb));
        check($sformatf("d%0d.hdata", g), 32'(u_if.hdata), 32'(o.h));
        check($sformatf("d%0d.vdata", g), 32'(u_if.vdata), 32'(o.v));
        check($sformatf("d%0d.hsync", g), 32'(u_if.hsync), 32'(o.hs));
        check($sformatf("d%0d.vsync", g), 32'(u_if.vsync), 32'(o.vs));
        check($sformatf("d%0d.data_enable", g), 32'(u_if.data_enable), 32'(o.de));
        check($sformatf("d%0d.frame_start", g), 32'(u_if.frame_start), 32'(o.fs));
        check($sformatf("d%0d.to_black", g), 32'(u_if.to_black), 32'(o.blk));
        mh++;
        if (mh == HM) begin
          mh = 0;
          mv = (mv + 1 == VM) ? 0 : mv + 1;
        end
      end
    end
  end

  task automatic wait_fs2(output int unsigned n_cyc, output int unsigned n_tb);
    bit seen;
    n_cyc = 0;
    n_tb  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(1);
      if (g_dut[2].u_if.frame_start) begin
        seen = 1'b1;
      end else begin
        n_cyc++;
        n_tb += 32'(g_dut[2].u_if.to_black);
      end
    end
    check("d2.frame_start_seen", 32'(seen), 1);
  endtask

  initial begin
    int rise_a, rise_b, fs_a, fs_b;
    int unsigned cnt_hs, cnt_vs, cnt_de, blank_bad, n_cyc, n_tb;
    logic prev_hs, prev_vs, prev_fs;

    step(3);
    check("rst.rgb444", 32'(g_dut[0].u_if.rgb444), 0);
    check("rst.fb_addr", 32'(g_dut[0].u_if.fb_addr), 0);
    check("rst.hsync", 32'(g_dut[0].u_if.hsync), 0);
    check("rst.vsync", 32'(g_dut[0].u_if.vsync), 0);
    check("rst.data_enable", 32'(g_dut[0].u_if.data_enable), 0);
    check("rst.frame_start", 32'(g_dut[0].u_if.frame_start), 0);
    check("rst.to_black", 32'(g_dut[0].u_if.to_black), 0);
    rst = 3'b000;

    // Full-timing instance: stage-0 index k equals posedges since release.
    check("first.fb_addr", 32'(g_dut[0].u_if.fb_addr), 0);
    step(1);
    check("first.fs_early", 32'(g_dut[0].u_if.frame_start), 0);
    step(1);
    check("first.rgb444", 32'(g_dut[0].u_if.rgb444), 32'h0ABC);
    check("first.data_enable", 32'(g_dut[0].u_if.data_enable), 1);
    check("first.frame_start", 32'(g_dut[0].u_if.frame_start), 1);
    step(1039);
    check("addr(1,1)", 32'(g_dut[0].u_if.fb_addr), 0);
    step(2);
    check("hdata(1,1)", 32'(g_dut[0].u_if.hdata), 1);
    check("vdata(1,1)", 32'(g_dut[0].u_if.vdata), 1);
    step(2079);
    check("addr(2,3)", 32'(g_dut[0].u_if.fb_addr), 401);
    step(2);
    check("hdata(2,3)", 32'(g_dut[0].u_if.hdata), 2);
    check("vdata(2,3)", 32'(g_dut[0].u_if.vdata), 3);
    check("rgb(2,3)", 32'(g_dut[0].u_if.rgb444), 32'(pat(401)));

    cnt_hs = 0; cnt_de = 0; blank_bad = 0; rise_a = -1; rise_b = -1;
    prev_hs = g_dut[0].u_if.hsync;
    for (int i = 0; i < 2080; i++) begin
      step(1);
      if (g_dut[0].u_if.hsync && !prev_hs) begin
        if (rise_a < 0) rise_a = i;
        else if (rise_b < 0) rise_b = i;
      end
      prev_hs = g_dut[0].u_if.hsync;
      if (i < 1040) begin
        cnt_hs += 32'(g_dut[0].u_if.hsync);
        cnt_de += 32'(g_dut[0].u_if.data_enable);
      end
      if (!g_dut[0].u_if.data_enable && g_dut[0].u_if.rgb444 != 12'h000) blank_bad++;
    end
    check("hsync_width", cnt_hs, 120);
    check("line_period", 32'(rise_b - rise_a), 1040);
    check("de_per_line", cnt_de, 800);
    check("blank_rgb_nonzero", blank_bad, 0);
    rst[0] = 1'b1;

    // Shrunken timing, latency 1: 24x12 frame of 288 cycles.
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; rise_a = -1; rise_b = -1; fs_a = -1; fs_b = -1;
    prev_vs = g_dut[1].u_if.vsync;
    prev_fs = g_dut[1].u_if.frame_start;
    for (int i = 0; i < 576; i++) begin
      step(1);
      if (g_dut[1].u_if.vsync && !prev_vs) begin
        if (rise_a < 0) rise_a = i;
        else if (rise_b < 0) rise_b = i;
      end
      if (g_dut[1].u_if.frame_start && !prev_fs) begin
        if (fs_a < 0) fs_a = i;
        else if (fs_b < 0) fs_b = i;
      end
      prev_vs = g_dut[1].u_if.vsync;
      prev_fs = g_dut[1].u_if.frame_start;
      if (i < 288) begin
        cnt_hs += 32'(g_dut[1].u_if.hsync);
        cnt_vs += 32'(g_dut[1].u_if.vsync);
        cnt_de += 32'(g_dut[1].u_if.data_enable);
      end
    end
    check("d1.vsync_cycles", cnt_vs, 48);
    check("d1.vsync_period", 32'(rise_b - rise_a), 288);
    check("d1.hsync_cycles", cnt_hs, 36);
    check("d1.de_per_frame", cnt_de, 128);
    check("d1.fs_period", 32'(fs_b - fs_a), 288);

    // Latency-4 instance: pause behaviour, then asynchronous mid-frame reset.
    wait_fs2(n_cyc, n_tb);
    step(100);
    pause[2] = 1'b1;
    wait_fs2(n_cyc, n_tb);
    check("pause.hold_low", n_tb, 0);
    check("pause.rise_at_fs", 32'(g_dut[2].u_if.to_black), 1);
    step(100);
    pause[2] = 1'b0;
    wait_fs2(n_cyc, n_tb);
    check("pause.hold_high", n_tb, n_cyc);
    check("pause.fall_at_fs", 32'(g_dut[2].u_if.to_black), 0);
    pause[2] = 1'b1;
    wait_fs2(n_cyc, n_tb);
    check("pause.rise_again", 32'(g_dut[2].u_if.to_black), 1);
    step(114);
    check("pre_rst.vdata", 32'(g_dut[2].u_if.vdata), 4);
    @(posedge clk);
    #3 rst[2] = 1'b1;
    #1;
    check("mid_rst.rgb444", 32'(g_dut[2].u_if.rgb444), 0);
    check("mid_rst.hdata", 32'(g_dut[2].u_if.hdata), 0);
    check("mid_rst.vdata", 32'(g_dut[2].u_if.vdata), 0);
    check("mid_rst.hsync", 32'(g_dut[2].u_if.hsync), 0);
    check("mid_rst.data_enable", 32'(g_dut[2].u_if.data_enable), 0);
    check("mid_rst.to_black", 32'(g_dut[2].u_if.to_black), 0);
    check("mid_rst.fb_addr", 32'(g_dut[2].u_if.fb_addr), 0);
    @(posedge clk);
    #1 rst[2] = 1'b0;
    step(3);
    check("restart.fs_early", 32'(g_dut[2].u_if.frame_start), 0);
    step(1);
    check("restart.frame_start", 32'(g_dut[2].u_if.frame_start), 1);
    check("restart.rgb444", 32'(g_dut[2].u_if.rgb444), 32'h0ABC);
    check("restart.vdata", 32'(g_dut[2].u_if.vdata), 0);
    check("restart.to_black", 32'(g_dut[2].u_if.to_black), 1);
    step(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
